butterfly_stage_param: RTL and testbench
========================================

Name: butterfly_stage_param

Overview:
- Parametrised radix-2 butterfly stage for the FFT datapath. It generalises the fixed 16-point, span-8 butterfly to any point count, pair distance and data width.
- Adds a valid/ready elastic 2-stage pipeline, per-transaction optional scale-by-2 with rounding, output saturation, a sticky overflow flag and an output block counter.
- Sits between the twiddle-multiply stage and the next butterfly stage or output reorder buffer.

Parameters:
N, 16, points per transaction (power of 2, >=2)
DIST, 8, butterfly pair distance (power of 2, 1..N/2)
IN_W, 15, signed input width per component
OUT_W, 16, signed output width per component (IN_W-1..IN_W+1)
CNT_W, 16, width of block counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
in_valid  in  1  input transaction valid
in_ready  out  1  stage can accept input this cycle
in_scale  in  1  1 = scale this transaction's results by 1/2 (rounded)
in_re  in  N x IN_W  signed real inputs [0:N-1]
in_im  in  N x IN_W  signed imag inputs [0:N-1]
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output
out_re  out  N x OUT_W  signed real outputs [0:N-1]
out_im  out  N x OUT_W  signed imag outputs [0:N-1]
ovf_clr  in  1  clear sticky overflow flag
ovf_sticky  out  1  set when any output component saturated since last clear
blk_cnt  out  CNT_W  count of completed output transactions (wraps)

Behaviour:
- Reset: one clock, rst = 1, synchronous. Clears s1_valid, out_valid, ovf_sticky, blk_cnt and all out_re/out_im to 0. rst asserted mid-operation discards in-flight data; no output handshake completes in that cycle.
- Pairing: for each index i with (i mod 2*DIST) < DIST:
  - A[i] = in[i] + in[i+DIST]
  - A[i+DIST] = in[i] - in[i+DIST]
  - Same rule for re and im. With N=16, DIST=8 this gives outputs 0..7 = sums and 8..15 = differences.
- S1 register (load on in_valid && in_ready):
  - Full-precision sums/differences, IN_W+1 bits, sign-extended.
  - in_scale is captured alongside the data.
- S2 / output register (load when s2_load):
  - If scale = 1: r = (A + 1) >>> 1, arithmetic shift, computed at IN_W+2 bits; i.e. round half toward +inf.
  - If scale = 0: r = A.
  - Then saturate r to OUT_W: clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- Handshake:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_load (combinational from out_ready allowed)
  - out_valid is set by s2_load and cleared on out_valid && out_ready && !s2_load.
  - out_re/out_im/out_valid hold stable while out_valid && !out_ready.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput is 1 transaction/cycle. Full backpressure holds 2 transactions, after which in_ready = 0.
- Overflow:
  - ovf_sticky is set in the cycle after any S2 load where a component clamped.
  - ovf_clr clears it; if a set and ovf_clr occur in the same cycle, set wins.
- blk_cnt increments by 1 on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- Simultaneous input handshake and output handshake in the same cycle: both complete, with no bubble inserted.

Decomposition:
- Shared package fft_pkg holds:
  - sat function, parametrised on width
  - round-shift helper
  - default width constants (FFT_N=16, BF_IN_W=15, BF_OUT_W=16)
- One natural sub-module: bfly_pair_calc. It is combinational: one pair's add/sub, scale, round and saturate, producing an ovf bit. It is instantiated N/2 times per component by a generate loop. The registers stay in butterfly_stage_param.

Test Plan:
- Defaults, no scale: in_re[0]=16383, in_re[8]=16383, in_im[3]=-16384, in_im[11]=-16384 -> 2 cycles later out_re[0]=32766, out_re[8]=0, out_im[3]=-32768, out_im[11]=0, ovf_sticky=0.
- Scale rounding: in_re[0]=3, in_re[8]=4, in_re[1]=-3, in_re[9]=-4, in_scale=1 -> out_re[0]=4, out_re[8]=0, out_re[1]=-3, out_re[9]=1.
- Saturation, OUT_W=15 instance: in_re[0]=16383, in_re[8]=1 -> out_re[0]=16383 (clamped), ovf_sticky=1 the next cycle. Pulse ovf_clr -> 0. Repeat with ovf_clr asserted in the set cycle -> stays 1.
- Backpressure: stream 5 transactions with out_ready=0 -> in_ready drops after 2 accepted. out_re stays stable. Release out_ready -> all 5 delivered in order, blk_cnt=5.
- DIST=1, N=4 instance: in_re = {1,2,3,4} -> out_re = {3,-1,7,-1}.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, blk_cnt=0, outputs 0, in_ready=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: default widths, rounding shift and saturation.
package fft_pkg;

    localparam int FFT_N    = 16;
    localparam int BF_IN_W  = 15;
    localparam int BF_OUT_W = 16;

    // Wide signed carrier used by the helpers so that any stage width fits.
    typedef logic signed [63:0] wide_t;

    // Halve with round-half-toward-+inf: (x + 1) >>> 1.
    function automatic wide_t rnd_shr1(input wide_t x);
        return (x + 64'sd1) >>> 1;
    endfunction

    function automatic wide_t sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic wide_t sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Clamp x into the signed range of a w-bit value.
    function automatic wide_t sat(input wide_t x, input int w);
        wide_t r;
        if (x > sat_hi(w)) begin
            r = sat_hi(w);
        end else if (x < sat_lo(w)) begin
            r = sat_lo(w);
        end else begin
            r = x;
        end
        return r;
    endfunction

    // True when sat() would have to clamp x.
    function automatic logic sat_hit(input wide_t x, input int w);
        return (x > sat_hi(w)) || (x < sat_lo(w));
    endfunction

endpackage

// File: rtl/bfly_pair_calc.sv
// One butterfly pair, one component: full-precision add/sub feeding S1, and
// the post-S1 scale/round/saturate path feeding the output register.
module bfly_pair_calc
    import fft_pkg::*;
#(
    parameter int IN_W  = BF_IN_W,
    parameter int OUT_W = BF_OUT_W
) (
    input  logic [IN_W-1:0]         a_i,
    input  logic [IN_W-1:0]         b_i,
    output logic [IN_W:0]           sum_o,
    output logic [IN_W:0]           dif_o,
    input  logic signed [IN_W:0]    s_sum_i,
    input  logic signed [IN_W:0]    s_dif_i,
    input  logic                    scale_i,
    output logic [OUT_W-1:0]        r_sum_o,
    output logic [OUT_W-1:0]        r_dif_o,
    output logic                    ovf_o
);

    wide_t x_sum, x_dif;

    // One extra bit is enough to hold any sum or difference exactly.
    assign sum_o = {a_i[IN_W-1], a_i} + {b_i[IN_W-1], b_i};
    assign dif_o = {a_i[IN_W-1], a_i} - {b_i[IN_W-1], b_i};

    // Optional rounded halving, then clamp to the output width.
    always_comb begin
        x_sum = {{(63-IN_W){s_sum_i[IN_W]}}, s_sum_i};
        x_dif = {{(63-IN_W){s_dif_i[IN_W]}}, s_dif_i};
        if (scale_i) begin
            x_sum = rnd_shr1(x_sum);
            x_dif = rnd_shr1(x_dif);
        end
        r_sum_o = OUT_W'(sat(x_sum, OUT_W));
        r_dif_o = OUT_W'(sat(x_dif, OUT_W));
        ovf_o   = sat_hit(x_sum, OUT_W) | sat_hit(x_dif, OUT_W);
    end

endmodule

// File: rtl/butterfly_stage_param.sv
// Parametrised radix-2 butterfly stage with a two-deep elastic pipeline:
// S1 holds full-precision sums/differences, S2 holds scaled, saturated results.
module butterfly_stage_param
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int DIST  = 8,
    parameter int IN_W  = BF_IN_W,
    parameter int OUT_W = BF_OUT_W,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_scale,
    input  logic [N-1:0][IN_W-1:0]     in_re,
    input  logic [N-1:0][IN_W-1:0]     in_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0][OUT_W-1:0]    out_re,
    output logic [N-1:0][OUT_W-1:0]    out_im,
    input  logic                       ovf_clr,
    output logic                       ovf_sticky,
    output logic [CNT_W-1:0]           blk_cnt
);

    logic [N-1:0][IN_W:0]    add_re, add_im;
    logic [N-1:0][IN_W:0]    s1_re_q, s1_im_q;
    logic [N-1:0][OUT_W-1:0] r_re, r_im;
    logic [N-1:0][OUT_W-1:0] out_re_q, out_im_q;
    logic [N/2-1:0]          ovf_re, ovf_im;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_scale_q;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             s2_load, in_fire, out_fire;

    // Pair p maps to lanes i and i+DIST, skipping the upper half of each 2*DIST block.
    for (genvar p = 0; p < N/2; p++) begin : g_pair
        localparam int I = (p / DIST) * 2 * DIST + (p % DIST);
        localparam int J = I + DIST;

        bfly_pair_calc #(.IN_W(IN_W), .OUT_W(OUT_W)) u_re (
            .a_i     (in_re[I]),
            .b_i     (in_re[J]),
            .sum_o   (add_re[I]),
            .dif_o   (add_re[J]),
            .s_sum_i (s1_re_q[I]),
            .s_dif_i (s1_re_q[J]),
            .scale_i (s1_scale_q),
            .r_sum_o (r_re[I]),
            .r_dif_o (r_re[J]),
            .ovf_o   (ovf_re[p])
        );

        bfly_pair_calc #(.IN_W(IN_W), .OUT_W(OUT_W)) u_im (
            .a_i     (in_im[I]),
            .b_i     (in_im[J]),
            .sum_o   (add_im[I]),
            .dif_o   (add_im[J]),
            .s_sum_i (s1_im_q[I]),
            .s_dif_i (s1_im_q[J]),
            .scale_i (s1_scale_q),
            .r_sum_o (r_im[I]),
            .r_dif_o (r_im[J]),
            .ovf_o   (ovf_im[p])
        );
    end

    // Handshake decode and next-state for the control registers.
    always_comb begin
        s2_load     = s1_valid_q && (!out_valid_q || out_ready);
        in_ready    = !s1_valid_q || s2_load;
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid_q && out_ready;

        s1_valid_d  = s1_valid_q;
        if (in_fire)      s1_valid_d = 1'b1;
        else if (s2_load) s1_valid_d = 1'b0;

        out_valid_d = out_valid_q;
        if (s2_load)       out_valid_d = 1'b1;
        else if (out_fire) out_valid_d = 1'b0;

        // A new clamp beats a clear arriving in the same cycle.
        ovf_d = ovf_q;
        if (s2_load && (|ovf_re || |ovf_im)) ovf_d = 1'b1;
        else if (ovf_clr)                    ovf_d = 1'b0;

        blk_cnt_d = out_fire ? blk_cnt_q + CNT_W'(1) : blk_cnt_q;
    end

    // Control state: valids, sticky overflow, block counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    // S1 capture of full-precision results and the per-transaction scale flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_scale_q <= 1'b0;
        end else if (in_fire) begin
            s1_re_q    <= add_re;
            s1_im_q    <= add_im;
            s1_scale_q <= in_scale;
        end
    end

    // Output register; holds while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_re_q <= '0;
            out_im_q <= '0;
        end else if (s2_load) begin
            out_re_q <= r_re;
            out_im_q <= r_im;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;
    assign ovf_sticky = ovf_q;
    assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_butterfly_stage_param.sv
// Directed bench for butterfly_stage_param: default, saturating and 4-point instances.
module tb_butterfly_stage_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Default instance: N=16, DIST=8, IN_W=15, OUT_W=16
    logic d_rst, d_iv, d_ir, d_sc, d_ov, d_or, d_clr, d_ovf;
    logic [15:0][14:0] d_re, d_im;
    logic [15:0][15:0] d_ore, d_oim;
    logic [15:0]       d_cnt;

    butterfly_stage_param dut_d (
        .clk(clk), .rst(d_rst), .in_valid(d_iv), .in_ready(d_ir), .in_scale(d_sc),
        .in_re(d_re), .in_im(d_im), .out_valid(d_ov), .out_ready(d_or),
        .out_re(d_ore), .out_im(d_oim), .ovf_clr(d_clr), .ovf_sticky(d_ovf), .blk_cnt(d_cnt)
    );

    // Saturating instance: OUT_W=15
    logic s_rst, s_iv, s_ir, s_sc, s_ov, s_or, s_clr, s_ovf;
    logic [15:0][14:0] s_re, s_im, s_ore, s_oim;
    logic [15:0]       s_cnt;

    butterfly_stage_param #(.OUT_W(15)) dut_s (
        .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir), .in_scale(s_sc),
        .in_re(s_re), .in_im(s_im), .out_valid(s_ov), .out_ready(s_or),
        .out_re(s_ore), .out_im(s_oim), .ovf_clr(s_clr), .ovf_sticky(s_ovf), .blk_cnt(s_cnt)
    );

    // Four-point instance: N=4, DIST=1
    logic f_rst, f_iv, f_ir, f_sc, f_ov, f_or, f_clr, f_ovf;
    logic [3:0][14:0] f_re, f_im;
    logic [3:0][15:0] f_ore, f_oim;
    logic [15:0]      f_cnt;

    butterfly_stage_param #(.N(4), .DIST(1)) dut_f (
        .clk(clk), .rst(f_rst), .in_valid(f_iv), .in_ready(f_ir), .in_scale(f_sc),
        .in_re(f_re), .in_im(f_im), .out_valid(f_ov), .out_ready(f_or),
        .out_re(f_ore), .out_im(f_oim), .ovf_clr(f_clr), .ovf_sticky(f_ovf), .blk_cnt(f_cnt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, ocnt, cyc;
        d_rst = 1; d_iv = 0; d_sc = 0; d_or = 1; d_clr = 0; d_re = '0; d_im = '0;
        s_rst = 1; s_iv = 0; s_sc = 0; s_or = 1; s_clr = 0; s_re = '0; s_im = '0;
        f_rst = 1; f_iv = 0; f_sc = 0; f_or = 1; f_clr = 0; f_re = '0; f_im = '0;
        @(negedge clk);
        @(negedge clk);
        d_rst = 0; s_rst = 0; f_rst = 0;

        // Reset state
        chk("rst_out_valid", d_ov, 0);
        chk("rst_blk_cnt", d_cnt, 0);
        chk("rst_ovf", d_ovf, 0);
        chk("rst_in_ready", d_ir, 1);
        chk("rst_out_re0", $signed(d_ore[0]), 0);
        chk("rst_out_im15", $signed(d_oim[15]), 0);

        // Defaults, no scale
        d_re[0] = 15'(16383); d_re[8] = 15'(16383);
        d_im[3] = 15'(-16384); d_im[11] = 15'(-16384);
        d_iv = 1;
        @(negedge clk);
        d_iv = 0;
        chk("lat_not_yet", d_ov, 0);
        @(negedge clk);
        chk("def_valid", d_ov, 1);
        chk("def_re0", $signed(d_ore[0]), 32766);
        chk("def_re8", $signed(d_ore[8]), 0);
        chk("def_im3", $signed(d_oim[3]), -32768);
        chk("def_im11", $signed(d_oim[11]), 0);
        chk("def_ovf", d_ovf, 0);
        @(negedge clk);
        chk("def_cnt", d_cnt, 1);
        chk("def_drained", d_ov, 0);

        // Scale rounding
        d_re = '0; d_im = '0;
        d_re[0] = 15'(3); d_re[8] = 15'(4); d_re[1] = 15'(-3); d_re[9] = 15'(-4);
        d_sc = 1; d_iv = 1;
        @(negedge clk);
        d_sc = 0; d_iv = 0;
        @(negedge clk);
        chk("scl_re0", $signed(d_ore[0]), 4);
        chk("scl_re8", $signed(d_ore[8]), 0);
        chk("scl_re1", $signed(d_ore[1]), -3);
        chk("scl_re9", $signed(d_ore[9]), 1);
        chk("scl_im0", $signed(d_oim[0]), 0);

        // Backpressure: five transactions, downstream stalled first
        d_rst = 1;
        @(negedge clk);
        d_rst = 0;
        d_or = 0; idx = 0; ocnt = 0; cyc = 0;
        for (int c = 0; c < 4; c++) begin
            d_re = '0; d_im = '0;
            d_iv = (idx < 5);
            d_re[0] = 15'(10 + idx);
            #1;
            if (c >= 2) begin
                chk("bp_hold_re", $signed(d_ore[0]), 10);
                chk("bp_hold_ready", d_ir, 0);
            end
            if (d_iv && d_ir) idx++;
            @(negedge clk);
        end
        chk("bp_accepted", idx, 2);
        chk("bp_valid", d_ov, 1);
        chk("bp_cnt_stall", d_cnt, 0);
        d_or = 1;
        while (ocnt < 5 && cyc < 30) begin
            d_re = '0; d_im = '0;
            d_iv = (idx < 5);
            d_re[0] = 15'(10 + idx);
            #1;
            if (d_ov && d_or) begin
                chk("bp_order", $signed(d_ore[0]), 10 + ocnt);
                ocnt++;
            end
            if (d_iv && d_ir) idx++;
            cyc++;
            @(negedge clk);
        end
        d_iv = 0;
        chk("bp_delivered", ocnt, 5);
        chk("bp_cnt", d_cnt, 5);
        chk("bp_empty", d_ov, 0);

        // Reset with both stages full
        d_or = 0;
        d_re = '0; d_re[0] = 15'(20); d_iv = 1;
        @(negedge clk);
        d_re[0] = 15'(21);
        @(negedge clk);
        d_iv = 0;
        chk("mid_full_valid", d_ov, 1);
        chk("mid_full_ready", d_ir, 0);
        d_rst = 1; d_or = 1;
        @(negedge clk);
        d_rst = 0;
        chk("mid_valid", d_ov, 0);
        chk("mid_cnt", d_cnt, 0);
        chk("mid_re0", $signed(d_ore[0]), 0);
        chk("mid_ready", d_ir, 1);
        @(negedge clk);
        chk("mid_s1_discarded", d_ov, 0);

        // Saturation on OUT_W=15
        s_re[0] = 15'(16383); s_re[8] = 15'(1);
        s_re[1] = 15'(-16384); s_re[9] = 15'(-16384);
        s_im[2] = 15'(-16384); s_im[10] = 15'(-1);
        s_iv = 1;
        @(negedge clk);
        s_iv = 0;
        chk("sat_ovf_before", s_ovf, 0);
        @(negedge clk);
        chk("sat_re0", $signed(s_ore[0]), 16383);
        chk("sat_re8", $signed(s_ore[8]), 16382);
        chk("sat_re1", $signed(s_ore[1]), -16384);
        chk("sat_re9", $signed(s_ore[9]), 0);
        chk("sat_im2", $signed(s_oim[2]), -16384);
        chk("sat_im10", $signed(s_oim[10]), -16383);
        chk("sat_ovf_set", s_ovf, 1);
        s_clr = 1;
        @(negedge clk);
        s_clr = 0;
        chk("sat_ovf_clr", s_ovf, 0);
        s_iv = 1;
        @(negedge clk);
        s_iv = 0; s_clr = 1;
        @(negedge clk);
        s_clr = 0;
        chk("sat_set_wins", s_ovf, 1);
        @(negedge clk);
        chk("sat_sticky_hold", s_ovf, 1);

        // Four-point, DIST=1
        f_re[0] = 15'(1); f_re[1] = 15'(2); f_re[2] = 15'(3); f_re[3] = 15'(4);
        f_iv = 1;
        @(negedge clk);
        f_iv = 0;
        @(negedge clk);
        chk("n4_re0", $signed(f_ore[0]), 3);
        chk("n4_re1", $signed(f_ore[1]), -1);
        chk("n4_re2", $signed(f_ore[2]), 7);
        chk("n4_re3", $signed(f_ore[3]), -1);
        chk("n4_im0", $signed(f_oim[0]), 0);
        @(negedge clk);
        chk("n4_cnt", f_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
